// File: rtl/zkey_event.sv
// rtl/zkey_event.sv - turns debounced button levels into queued PRESS/RELEASE/LONG/REPEAT key events
module zkey_event #(
    parameter logic [23:0] LONG_CNT   = 24'd5_000_000,
    parameter logic [23:0] REP_CNT    = 24'd1_000_000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] iButton,
    output logic       oEvtValid,
    input  logic       iEvtReady,
    output logic [1:0] oEvtKey,
    output logic [1:0] oEvtType,
    output logic       oOverflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] EV_PRESS   = 2'd0;
    localparam logic [1:0] EV_RELEASE = 2'd1;
    localparam logic [1:0] EV_LONG    = 2'd2;
    localparam logic [1:0] EV_REPEAT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RPT  = 2'd2
    } state_t;

    state_t      state_q [4];
    state_t      state_d [4];
    logic [23:0] cnt_q   [4];
    logic [23:0] cnt_d   [4];
    logic [3:0]  prev_q;
    logic [3:0]  rise;
    logic [3:0]  fall;
    logic [3:0]  ev_fire;
    logic [1:0]  ev_type [4];

    logic [3:0]  slot_vld_q;
    logic [1:0]  slot_type_q [4];

    logic [3:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        fifo_empty;
    logic        fifo_full;
    logic        pop;
    logic        push;
    logic        sel_vld;
    logic [1:0]  sel_idx;

    assign rise = iButton & ~prev_q;
    assign fall = ~iButton & prev_q;

    // prev tracks the level even while disabled, so a key held across en rising gives no PRESS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 4'b0000;
        end else begin
            prev_q <= iButton;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= 24'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // A fall is checked first so it wins over a LONG/REPEAT in the same cycle
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            ev_fire[i] = 1'b0;
            ev_type[i] = EV_PRESS;
            if (!en) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = 24'd0;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (rise[i]) begin
                            ev_fire[i] = 1'b1;
                            ev_type[i] = EV_PRESS;
                            cnt_d[i]   = 24'd1;
                            state_d[i] = ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (fall[i]) begin
                            ev_fire[i] = 1'b1;
                            ev_type[i] = EV_RELEASE;
                            cnt_d[i]   = 24'd0;
                            state_d[i] = ST_IDLE;
                        end else if (cnt_q[i] == LONG_CNT) begin
                            ev_fire[i] = 1'b1;
                            ev_type[i] = EV_LONG;
                            cnt_d[i]   = 24'd1;
                            state_d[i] = ST_RPT;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 24'd1;
                        end
                    end
                    ST_RPT: begin
                        if (fall[i]) begin
                            ev_fire[i] = 1'b1;
                            ev_type[i] = EV_RELEASE;
                            cnt_d[i]   = 24'd0;
                            state_d[i] = ST_IDLE;
                        end else if (cnt_q[i] == REP_CNT) begin
                            ev_fire[i] = 1'b1;
                            ev_type[i] = EV_REPEAT;
                            cnt_d[i]   = 24'd1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 24'd1;
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = 24'd0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        sel_vld = 1'b0;
        sel_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (slot_vld_q[i]) begin
                sel_vld = 1'b1;
                sel_idx = 2'(i);
            end
        end
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
    assign pop        = ~fifo_empty & iEvtReady;
    assign push       = sel_vld & (~fifo_full | pop);

    // Occupancy is judged on the registered flag: a slot drained this cycle still rejects a new event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                slot_type_q[i] <= 2'd0;
            end
            oOverflow <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (slot_vld_q[i]) begin
                    if (push && (sel_idx == 2'(i))) begin
                        slot_vld_q[i] <= 1'b0;
                    end
                end else if (ev_fire[i]) begin
                    slot_vld_q[i]  <= 1'b1;
                    slot_type_q[i] <= ev_type[i];
                end
            end
            if (|(ev_fire & slot_vld_q)) begin
                oOverflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 4'd0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= {sel_idx, slot_type_q[sel_idx]};
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign oEvtValid = ~fifo_empty;
    assign oEvtKey   = mem_q[rd_ptr_q[AW-1:0]][3:2];
    assign oEvtType  = mem_q[rd_ptr_q[AW-1:0]][1:0];

endmodule

// File: tb/tb_zkey_event.sv
// tb/tb_zkey_event.sv - directed vector bench for zkey_event
module tb_zkey_event;

    localparam logic [1:0] P = 2'd0;
    localparam logic [1:0] R = 2'd1;
    localparam logic [1:0] L = 2'd2;
    localparam logic [1:0] T = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic [3:0] iButton = 4'b0000;
    logic       iEvtReady = 1'b1;
    logic       oEvtValid;
    logic [1:0] oEvtKey;
    logic [1:0] oEvtType;
    logic       oOverflow;

    int tests = 0;
    int fails = 0;

    zkey_event #(
        .LONG_CNT  (24'd10),
        .REP_CNT   (24'd4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .iButton  (iButton),
        .oEvtValid(oEvtValid),
        .iEvtReady(iEvtReady),
        .oEvtKey  (oEvtKey),
        .oEvtType (oEvtType),
        .oOverflow(oOverflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] btn;
        logic       rdy;
        logic       vld;
        logic [1:0] key;
        logic [1:0] typ;
        logic       ovf;
    } vec_t;

    vec_t vt[21];

    function automatic vec_t mk(input logic e, input logic [3:0] b, input logic r,
                                input logic v, input logic [1:0] k, input logic [1:0] t,
                                input logic o);
        vec_t x;
        x.en = e; x.btn = b; x.rdy = r; x.vld = v; x.key = k; x.typ = t; x.ovf = o;
        return x;
    endfunction

    task automatic step(input logic e, input logic [3:0] b, input logic r);
        @(negedge clk);
        en = e;
        iButton = b;
        iEvtReady = r;
        @(posedge clk);
        #1;
    endtask

    // Key/type are only meaningful while valid is high
    task automatic check(input string name, input logic ev, input logic [1:0] ek,
                         input logic [1:0] et, input logic eo);
        tests++;
        if (oEvtValid !== ev || oOverflow !== eo ||
            (ev && (oEvtKey !== ek || oEvtType !== et))) begin
            fails++;
            $display("FAIL %s: got v=%0b k=%0d t=%0d o=%0b, want v=%0b k=%0d t=%0d o=%0b",
                     name, oEvtValid, oEvtKey, oEvtType, oOverflow, ev, ek, et, eo);
        end
    endtask

    task automatic check_zero(input string name);
        tests++;
        if (oEvtValid !== 1'b0 || oEvtKey !== 2'd0 || oEvtType !== 2'd0 || oOverflow !== 1'b0) begin
            fails++;
            $display("FAIL %s: got v=%0b k=%0d t=%0d o=%0b, want all 0",
                     name, oEvtValid, oEvtKey, oEvtType, oOverflow);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        en = 1'b1;
        iButton = 4'b0000;
        iEvtReady = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = mk(1, 4'b0000, 1, 0, 0, 0, 0);
        vt[1]  = mk(1, 4'b0001, 1, 0, 0, 0, 0);
        vt[2]  = mk(1, 4'b0001, 1, 1, 0, P, 0);
        vt[3]  = mk(1, 4'b0001, 1, 0, 0, 0, 0);
        vt[4]  = mk(1, 4'b0001, 1, 0, 0, 0, 0);
        vt[5]  = mk(1, 4'b0001, 1, 0, 0, 0, 0);
        vt[6]  = mk(1, 4'b0000, 1, 0, 0, 0, 0);
        vt[7]  = mk(1, 4'b0000, 1, 1, 0, R, 0);
        vt[8]  = mk(1, 4'b0000, 1, 0, 0, 0, 0);
        vt[9]  = mk(1, 4'b1111, 1, 0, 0, 0, 0);
        vt[10] = mk(1, 4'b1111, 1, 1, 0, P, 0);
        vt[11] = mk(1, 4'b1111, 1, 1, 1, P, 0);
        vt[12] = mk(1, 4'b1111, 1, 1, 2, P, 0);
        vt[13] = mk(1, 4'b1111, 1, 1, 3, P, 0);
        vt[14] = mk(1, 4'b1111, 1, 0, 0, 0, 0);
        vt[15] = mk(1, 4'b0000, 1, 0, 0, 0, 0);
        vt[16] = mk(1, 4'b0000, 1, 1, 0, R, 0);
        vt[17] = mk(1, 4'b0000, 1, 1, 1, R, 0);
        vt[18] = mk(1, 4'b0000, 1, 1, 2, R, 0);
        vt[19] = mk(1, 4'b0000, 1, 1, 3, R, 0);
        vt[20] = mk(1, 4'b0000, 1, 0, 0, 0, 0);

        #12;
        check_zero("reset_state");
        do_reset();

        // short press then simultaneous press of all four keys
        for (int i = 0; i < 21; i++) begin
            step(vt[i].en, vt[i].btn, vt[i].rdy);
            check($sformatf("vec%0d", i), vt[i].vld, vt[i].key, vt[i].typ, vt[i].ovf);
        end

        // long hold on key 2: PRESS, LONG +10, REPEAT +14/+18, RELEASE
        do_reset();
        for (int t = 0; t <= 22; t++) begin
            logic       v;
            logic [1:0] ty;
            step(1'b1, (t <= 20) ? 4'b0100 : 4'b0000, 1'b1);
            v = 1'b1;
            case (t)
                1:       ty = P;
                11:      ty = L;
                15, 19:  ty = T;
                22:      ty = R;
                default: begin v = 1'b0; ty = P; end
            endcase
            check($sformatf("long_t%0d", t), v, 2'd2, ty, 1'b0);
        end

        // backpressure: fill FIFO and the key0 slot, then overflow and drain
        do_reset();
        for (int t = 0; t < 12; t++) begin
            step(1'b1, ((t % 4) < 2) ? 4'b0001 : 4'b0000, 1'b0);
            check($sformatf("bp_t%0d", t), (t >= 1), 2'd0, P, (t >= 10));
        end
        begin
            logic [1:0] drain [5];
            drain[0] = R; drain[1] = P; drain[2] = R; drain[3] = P; drain[4] = P;
            for (int t = 0; t < 5; t++) begin
                step(1'b1, 4'b0000, 1'b1);
                check($sformatf("drain_t%0d", t), (t < 4), 2'd0, drain[t], 1'b1);
            end
        end

        // en gating
        do_reset();
        for (int t = 0; t < 3; t++) begin
            step(1'b0, 4'b0001, 1'b1);
            check($sformatf("en0_held_t%0d", t), 1'b0, 0, 0, 1'b0);
        end
        for (int t = 0; t < 14; t++) begin
            step(1'b1, 4'b0001, 1'b1);
            check($sformatf("en1_held_t%0d", t), 1'b0, 0, 0, 1'b0);
        end
        for (int t = 0; t < 3; t++) begin
            step(1'b1, 4'b0000, 1'b1);
            check($sformatf("en1_rel_t%0d", t), 1'b0, 0, 0, 1'b0);
        end
        for (int t = 0; t < 3; t++) begin
            step(1'b1, 4'b0001, 1'b1);
            check($sformatf("en1_press_t%0d", t), (t == 1), 2'd0, P, 1'b0);
        end
        for (int t = 0; t < 14; t++) begin
            step(1'b0, 4'b0001, 1'b1);
            check($sformatf("en_drop_t%0d", t), 1'b0, 0, 0, 1'b0);
        end
        for (int t = 0; t < 5; t++) begin
            step(1'b1, 4'b0001, 1'b1);
            check($sformatf("en_back_t%0d", t), 1'b0, 0, 0, 1'b0);
        end

        // asynchronous reset mid-REPEAT with queued events
        do_reset();
        for (int t = 0; t < 16; t++) begin
            step(1'b1, 4'b0100, 1'b0);
        end
        check("queued_before_reset", 1'b1, 2'd2, P, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        en = 1'b0;
        rst_n = 1'b1;
        step(1'b0, 4'b0100, 1'b1);
        step(1'b0, 4'b0100, 1'b1);
        for (int t = 0; t < 15; t++) begin
            step(1'b1, 4'b0100, 1'b1);
            check($sformatf("post_reset_t%0d", t), 1'b0, 0, 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
